group_sel_sequencer: RTL and testbench
======================================

// Module: group_sel_sequencer
// PURPOSE
//  Drives the 4-bit project-select of the 16-way group output mux (uo_out = proj_out[sel]).
//  Two modes:
//   - manual: follow a host-supplied index.
//   - auto: round-robin over an enable mask with a programmable dwell time.
//  Every select change is framed by a blanking window so downstream logic can gate off switching glitches.
// PARAMETERS
//  NUM_PROJ      16  number of mux slots; SEL_W = clog2(NUM_PROJ)
//  SEL_W         4   width of select index
//  DWELL_W       16  width of dwell counter / dwell input
//  BLANK_CYCLES  2   cycles blank stays high after each select change (>=1)
// PORTS
//  clk           in   1         system clock
//  rst_n         in   1         reset, synchronous, active-low
//  ena           in   1         sequencer enable; low forces OFF
//  mode          in   1         0 = manual, 1 = auto
//  man_sel       in   SEL_W     manual target index (ignores en_mask)
//  en_mask       in   NUM_PROJ  auto mode: bit i = slot i eligible
//  dwell         in   DWELL_W   auto mode: cycles per slot in RUN; 0 = advance on step only
//  step          in   1         auto mode: 1-cycle pulse forces advance to next slot
//  sel           out  SEL_W     registered mux select
//  blank         out  1         high = output invalid; gate the mux output
//  sel_valid     out  1         ~blank, registered
//  switch_pulse  out  1         1-cycle pulse on the cycle sel takes a new value
// BEHAVIOUR
//  Clock and reset
//   - One clock; all outputs registered.
//   - Reset is synchronous, active-low: rst_n=0 at a clk edge -> state OFF, sel=0, blank=1, sel_valid=0, switch_pulse=0, counters=0.
//  States: OFF, BLANK, RUN.
//  OFF
//   - blank=1; sel holds its last value.
//   - Exit when ena=1 and a target exists:
//     - manual: target = man_sel.
//     - auto: target = lowest set bit of en_mask.
//   - On exit -> BLANK: sel<=target, switch_pulse=1, even if target==sel.
//   - Auto with en_mask==0: stay in OFF.
//  BLANK
//   - blank=1; counts BLANK_CYCLES cycles, including the entry cycle, then -> RUN.
//   - Inputs are not re-evaluated until RUN, except ena and reset.
//  RUN
//   - blank=0, sel_valid=1; dwell counter runs in auto mode.
//   - Manual: man_sel != sel -> BLANK with sel<=man_sel.
//   - Auto: advance when any of these holds:
//     - dwell!=0 and counter==dwell-1;
//     - step=1;
//     - en_mask[sel]==0 (current slot disabled).
//   - Advance target = next set bit of en_mask searching sel+1, sel+2, ... with wrap from NUM_PROJ-1 to 0.
//     - Target == sel (single slot enabled): stay in RUN, counter<=0, no blank, no switch_pulse.
//     - en_mask==0: -> OFF.
//   - Counter resets to 0 on every entry to RUN and on every advance.
//  Priority, highest first: rst_n, ena=0 (-> OFF next edge, blank=1), mode change, step, dwell expiry.
//   - A mode toggle in RUN or BLANK -> BLANK with the new mode's target, as from OFF.
//   - step and dwell expiry on the same cycle: single advance, not two.
//   - step in OFF or BLANK: ignored, not queued.
//  Latency
//   - man_sel change in RUN -> sel updates 1 cycle later.
//   - blank falls BLANK_CYCLES cycles after switch_pulse.
//  Counter arithmetic: unsigned DWELL_W bits, never wraps, because it is compared against dwell-1 with dwell!=0.
// TESTING
//  1 Reset: rst_n=0 for 2 clk with ena=1 -> sel=0, blank=1, sel_valid=0, switch_pulse=0; release -> switch_pulse at cycle 1, blank low at cycle 1+BLANK_CYCLES.
//  2 Manual: mode=0, man_sel=5 -> sel=5; set man_sel=11 in RUN -> sel=11 next cycle, switch_pulse=1, blank high exactly 2 cycles.
//  3 Auto wrap: mode=1, en_mask=16'h8005, dwell=4 -> sel order 0,2,15,0,...; each slot visible 4 RUN cycles plus 2 blank.
//  4 Single slot / step: en_mask=16'h0010, step pulses -> sel stays 4, blank never rises after the first entry; step+expiry same cycle with en_mask=16'h0003 -> exactly one advance.
//  5 Mask edge: in RUN on sel=2 clear en_mask[2] -> advance to next enabled; set en_mask=0 -> OFF, blank=1; restore mask -> restart at lowest set bit.
//  6 Abort: drop ena mid-BLANK -> OFF next edge; assert rst_n=0 mid-RUN -> all reset values next edge.

Source files
------------

// File: rtl/group_sel_sequencer.sv
// Purpose : sequences the 4-bit project select of the 16-way group output mux; manual index or auto round-robin.
// Latency : all outputs registered; a new select appears 1 cycle after its cause, blank falls BLANK_CYCLES later.
// Backpres: none; step is a fire-and-forget pulse, dropped outside RUN.
//
// Ports:
//   clk, rst_n     clock; synchronous active-low reset
//   ena            low forces OFF (blank=1, sel held)
//   mode           0 = manual (man_sel), 1 = auto (round-robin over en_mask)
//   man_sel        manual target index
//   en_mask        auto eligibility mask, bit i = slot i
//   dwell          auto cycles per slot in RUN; 0 = advance on step only
//   step           auto one-cycle advance request
//   sel            registered mux select
//   blank          high while the mux output must be gated
//   sel_valid      registered ~blank
//   switch_pulse   one-cycle pulse on the cycle sel takes a new value
module group_sel_sequencer #(
  parameter int NUM_PROJ     = 16,
  parameter int SEL_W        = $clog2(NUM_PROJ),
  parameter int DWELL_W      = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                mode,
  input  logic [SEL_W-1:0]    man_sel,
  input  logic [NUM_PROJ-1:0] en_mask,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic                step,
  output logic [SEL_W-1:0]    sel,
  output logic                blank,
  output logic                sel_valid,
  output logic                switch_pulse
);

  localparam int BCNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  typedef enum logic [1:0] {S_OFF, S_BLANK, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [DWELL_W-1:0]  dcnt_q, dcnt_d;
  logic                mode_q;

  logic                take;      // load sel with new_sel and pulse switch_pulse
  logic [SEL_W-1:0]    new_sel;
  logic [SEL_W-1:0]    sel_d;
  logic                blank_d, pulse_d;

  logic [SEL_W-1:0]    low_idx;   // lowest set bit of en_mask
  logic [SEL_W-1:0]    next_idx;  // next set bit after sel, wrapping; sel itself last
  logic                mask_any;
  logic [SEL_W-1:0]    ent_tgt;
  logic                ent_ok;
  logic                mode_chg;
  logic                dwell_hit;
  logic                advance;
  logic [SEL_W:0]      j;

  // Slot search. Both loops run from the lowest-priority candidate to the
  // highest so the last match written wins.
  always_comb begin
    low_idx  = '0;
    next_idx = sel;
    j        = '0;
    mask_any = |en_mask;
    for (int i = NUM_PROJ - 1; i >= 0; i--) begin
      if (en_mask[SEL_W'(i)]) low_idx = SEL_W'(i);
    end
    for (int i = NUM_PROJ; i >= 1; i--) begin
      j = {1'b0, sel} + (SEL_W+1)'(i);
      if (j >= (SEL_W+1)'(NUM_PROJ)) j = j - (SEL_W+1)'(NUM_PROJ);
      if (en_mask[j[SEL_W-1:0]]) next_idx = j[SEL_W-1:0];
    end
  end

  assign ent_tgt   = mode ? low_idx : man_sel;
  assign ent_ok    = !mode || mask_any;
  assign mode_chg  = (mode != mode_q);
  assign dwell_hit = (dwell != '0) && (dcnt_q == dwell - 1'b1);
  // step and expiry together still give a single advance.
  assign advance   = step || dwell_hit || !en_mask[sel];

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_OFF;
      bcnt_q       <= '0;
      dcnt_q       <= '0;
      mode_q       <= 1'b0;
      sel          <= '0;
      blank        <= 1'b1;
      sel_valid    <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      dcnt_q       <= dcnt_d;
      mode_q       <= mode;
      sel          <= sel_d;
      blank        <= blank_d;
      sel_valid    <= ~blank_d;
      switch_pulse <= pulse_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    dcnt_d  = dcnt_q;
    take    = 1'b0;
    new_sel = sel;
    if (!ena) begin
      state_d = S_OFF;
    end else if (state_q == S_OFF || mode_chg) begin
      // Fresh entry: a mode toggle restarts exactly like leaving OFF, and the
      // pulse fires even if the target equals the current select.
      if (ent_ok) begin
        state_d = S_BLANK;
        bcnt_d  = '0;
        take    = 1'b1;
        new_sel = ent_tgt;
      end else begin
        state_d = S_OFF;
      end
    end else if (state_q == S_BLANK) begin
      // Entry cycle counts as the first blank cycle.
      if (bcnt_q == BCNT_W'(BLANK_CYCLES - 1)) begin
        state_d = S_RUN;
        dcnt_d  = '0;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end else if (!mode) begin
      if (man_sel != sel) begin
        state_d = S_BLANK;
        bcnt_d  = '0;
        take    = 1'b1;
        new_sel = man_sel;
      end
    end else if (advance) begin
      dcnt_d = '0;
      if (!mask_any) begin
        state_d = S_OFF;
      end else if (next_idx != sel) begin
        state_d = S_BLANK;
        bcnt_d  = '0;
        take    = 1'b1;
        new_sel = next_idx;
      end
    end else if (dwell != '0) begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  // Output logic (values registered on the next edge).
  always_comb begin
    sel_d   = take ? new_sel : sel;
    pulse_d = take;
    blank_d = (state_d != S_RUN);
  end

endmodule

// File: tb/tb_group_sel_sequencer.sv
// Purpose : randomized scoreboard bench for group_sel_sequencer against a cycle-level behavioural model.
// Latency : expected outputs pushed when inputs are applied, popped one edge later by the monitor.
// Backpres: none.
module tb_group_sel_sequencer;

  localparam int NUM_PROJ = 16;
  localparam int SEL_W    = 4;
  localparam int DWELL_W  = 16;
  localparam int BC       = 2;

  logic                clk;
  logic                rst_n, ena, mode, step;
  logic [SEL_W-1:0]    man_sel;
  logic [NUM_PROJ-1:0] en_mask;
  logic [DWELL_W-1:0]  dwell;
  logic [SEL_W-1:0]    sel;
  logic                blank, sel_valid, switch_pulse;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             blank;
    logic             valid;
    logic             pulse;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Model: "off", cycles elapsed since the last select change, dwell count.
  logic             m_off;
  int               m_age;
  int               m_dwc;
  logic [SEL_W-1:0] m_sel;
  logic             m_sw;
  logic             m_mode_prev;

  group_sel_sequencer #(
    .NUM_PROJ(NUM_PROJ), .SEL_W(SEL_W), .DWELL_W(DWELL_W), .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .man_sel(man_sel),
    .en_mask(en_mask), .dwell(dwell), .step(step), .sel(sel), .blank(blank),
    .sel_valid(sel_valid), .switch_pulse(switch_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lowest(input logic [NUM_PROJ-1:0] m);
    for (int k = 0; k < NUM_PROJ; k++) begin
      int idx;
      idx = k;
      if (m[idx[SEL_W-1:0]]) return k;
    end
    return -1;
  endfunction

  function automatic int next_after(input logic [SEL_W-1:0] s, input logic [NUM_PROJ-1:0] m);
    for (int k = 1; k <= NUM_PROJ; k++) begin
      int idx;
      idx = (int'(s) + k) % NUM_PROJ;
      if (m[idx[SEL_W-1:0]]) return idx;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge using the inputs now applied.
  task automatic apply();
    int   t;
    logic bl;
    m_sw = 1'b0;
    if (!rst_n) begin
      m_off = 1'b1; m_sel = '0; m_age = BC; m_dwc = 0; m_mode_prev = 1'b0;
    end else begin
      if (!ena) begin
        m_off = 1'b1;
      end else if (m_off || mode != m_mode_prev) begin
        t = mode ? lowest(en_mask) : int'(man_sel);
        if (t < 0) m_off = 1'b1;
        else begin m_off = 1'b0; m_sel = SEL_W'(t); m_sw = 1'b1; m_age = 0; end
      end else if (m_age < BC) begin
        m_age++;
        if (m_age == BC) m_dwc = 0;
      end else if (!mode) begin
        if (man_sel != m_sel) begin m_sel = man_sel; m_sw = 1'b1; m_age = 0; end
      end else if (step || (dwell != 0 && m_dwc == int'(dwell) - 1) || !en_mask[m_sel]) begin
        m_dwc = 0;
        t = next_after(m_sel, en_mask);
        if (t < 0) m_off = 1'b1;
        else if (SEL_W'(t) != m_sel) begin m_sel = SEL_W'(t); m_sw = 1'b1; m_age = 0; end
      end else if (dwell != 0) begin
        m_dwc++;
      end
      m_mode_prev = mode;
    end
    bl = m_off || (m_age < BC);
    exp_q.push_back({m_sel, bl, ~bl, m_sw});
  endtask

  task automatic run_cycles(input int n, input int step_pct);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      step = (!step && ($urandom_range(0, 99) < step_pct));
      apply();
    end
    @(negedge clk);
    step = 1'b0;
    apply();
  endtask

  // Monitor: compare every observed output set against the scoreboard.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {sel, blank, sel_valid, switch_pulse};
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL cyc %0d outputs sel/blank/valid/pulse got %h/%b/%b/%b want %h/%b/%b/%b",
                      cyc, a.sel, a.blank, a.valid, a.pulse, e.sel, e.blank, e.valid, e.pulse);
      end
    end
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; mode = 1'b0; man_sel = '0;
    en_mask = '0; dwell = '0; step = 1'b0;
    m_off = 1'b1; m_sel = '0; m_age = BC; m_dwc = 0; m_sw = 1'b0; m_mode_prev = 1'b0;

    // Reset held two cycles with ena high, then release.
    repeat (2) begin @(negedge clk); apply(); end
    @(negedge clk); rst_n = 1'b1; apply();
    run_cycles(6, 0);

    // Manual selection.
    @(negedge clk); man_sel = 4'd5; apply();
    run_cycles(8, 0);
    @(negedge clk); man_sel = 4'd11; apply();
    run_cycles(8, 0);
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) man_sel = SEL_W'($urandom_range(0, NUM_PROJ - 1));
      apply();
    end
    @(negedge clk); man_sel = 4'd11; apply();
    run_cycles(4, 0);

    // Auto round-robin with wrap.
    @(negedge clk); mode = 1'b1; en_mask = 16'h8005; dwell = 16'd4; apply();
    run_cycles(60, 0);

    // Single slot with steps, then step vs dwell expiry.
    @(negedge clk); en_mask = 16'h0010; dwell = 16'd0; apply();
    run_cycles(40, 30);
    @(negedge clk); en_mask = 16'h0003; dwell = 16'd3; apply();
    run_cycles(80, 35);

    // Mask edges.
    @(negedge clk); en_mask = 16'h0107; dwell = 16'd5; apply();
    for (int k = 0; k < 100 && !(m_sel == 4'd2 && !m_off && m_age >= BC); k++) begin
      @(negedge clk); apply();
    end
    @(negedge clk); en_mask = 16'h0103; apply();
    run_cycles(10, 0);
    @(negedge clk); en_mask = 16'h0000; apply();
    run_cycles(6, 0);
    @(negedge clk); en_mask = 16'h0030; apply();
    run_cycles(12, 0);

    // Aborts: ena low mid-blank, reset mid-run.
    @(negedge clk); mode = 1'b0; man_sel = 4'd7; apply();
    run_cycles(4, 0);
    @(negedge clk); man_sel = 4'd9; apply();
    @(negedge clk); ena = 1'b0; apply();
    run_cycles(3, 0);
    @(negedge clk); ena = 1'b1; apply();
    run_cycles(6, 0);
    @(negedge clk); rst_n = 1'b0; apply();
    @(negedge clk); rst_n = 1'b1; apply();
    run_cycles(6, 0);

    // Fully random traffic. dwell only moves while the block is forced OFF.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 39) == 0) ena = ~ena;
      if (!ena || !rst_n) dwell = DWELL_W'($urandom_range(0, 6));
      if ($urandom_range(0, 59) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0) man_sel = SEL_W'($urandom_range(0, NUM_PROJ - 1));
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 7) == 0) en_mask = '0;
        else en_mask = NUM_PROJ'($urandom & $urandom);
      end
      step = (!step && ($urandom_range(0, 6) == 0));
      apply();
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain scoreboard entries left %0d want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
